// File: rtl/seq_pkg.sv
// Shared types and defaults for the sequence slice player.
package seq_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 14;
    localparam int unsigned DEF_DATA_WIDTH = 64;
    localparam int unsigned NUM_CH         = 4;
    localparam int unsigned CH_WIDTH       = DEF_DATA_WIDTH / NUM_CH;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_RUN  = 2'd1,
        SEQ_DONE = 2'd2
    } seq_state_t;

    // One slice word: four 16-bit DAC channel values, ch0 in the low bits.
    typedef struct packed {
        logic [CH_WIDTH-1:0] ch3;
        logic [CH_WIDTH-1:0] ch2;
        logic [CH_WIDTH-1:0] ch1;
        logic [CH_WIDTH-1:0] ch0;
    } slice_t;

endpackage

// File: rtl/slice_addr_gen.sv
// Step detection, wrapping slot counter, repetition counter and control FSM.
module slice_addr_gen
    import seq_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  areset,
    input  logic                  enable,
    input  logic [31:0]           step_counter,
    input  logic [ADDR_WIDTH:0]   seq_length,
    input  logic [31:0]           num_repetitions,
    output logic                  fetch_req,
    output logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic [31:0]           rep_count,
    output seq_state_t            state,
    output logic                  error
);

    localparam logic [ADDR_WIDTH:0] ADDR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    seq_state_t          state_q, state_d;
    logic [31:0]         prev_q, prev_d;
    logic [ADDR_WIDTH:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0] len_q, len_d;
    logic [31:0]         reps_q, reps_d;
    logic [31:0]         rep_q, rep_d;
    logic                err_q, err_d;
    logic                req_q, req_d;
    logic [31:0]         delta;
    logic [31:0]         rep_inc;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q <= SEQ_IDLE;
            prev_q  <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            reps_q  <= '0;
            rep_q   <= '0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            reps_q  <= reps_d;
            rep_q   <= rep_d;
            err_q   <= err_d;
            req_q   <= req_d;
        end
    end

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        addr_d  = addr_q;
        len_d   = len_q;
        reps_d  = reps_q;
        rep_d   = rep_q;
        err_d   = err_q;
        req_d   = 1'b0;
        delta   = step_counter - prev_q;
        rep_inc = rep_q + 32'd1;

        // Dropping enable wins over any step seen in the same cycle.
        if (!enable) begin
            state_d = SEQ_IDLE;
        end else begin
            case (state_q)
                SEQ_IDLE: begin
                    len_d  = seq_length;
                    reps_d = num_repetitions;
                    prev_d = step_counter;
                    addr_d = '0;
                    rep_d  = '0;
                    if (seq_length == '0) begin
                        state_d = SEQ_DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = SEQ_RUN;
                        err_d   = 1'b0;
                        req_d   = 1'b1;
                    end
                end
                SEQ_RUN: begin
                    if (delta != '0) begin
                        prev_d = step_counter;
                        if (delta != 32'd1)
                            err_d = 1'b1;
                        if (addr_q == len_q - ADDR_ONE) begin
                            addr_d = '0;
                            rep_d  = rep_inc;
                            if (reps_q != '0 && rep_inc == reps_q)
                                state_d = SEQ_DONE;
                            else
                                req_d = 1'b1;
                        end else begin
                            addr_d = addr_q + ADDR_ONE;
                            req_d  = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign fetch_req  = req_q;
    assign fetch_addr = addr_q[ADDR_WIDTH-1:0];
    assign rep_count  = rep_q;
    assign state      = state_q;
    assign error      = err_q;

endmodule

// File: rtl/sequence_slice_player.sv
// Plays sequence slices out of BRAM, one slot per step-counter increment,
// with a read stage and a present stage that are flushed when enable drops.
module sequence_slice_player
    import seq_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  areset,
    input  logic                  enable,
    input  logic [31:0]           step_counter,
    input  logic [ADDR_WIDTH:0]   seq_length,
    input  logic [31:0]           num_repetitions,
    output logic                  bram_en,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    input  logic [DATA_WIDTH-1:0] bram_rdata,
    output logic [DATA_WIDTH-1:0] slice_data,
    output logic                  slice_valid,
    output logic [ADDR_WIDTH-1:0] slice_index,
    output logic [31:0]           rep_count,
    output logic [1:0]            state,
    output logic                  done,
    output logic                  error
);

    logic                  fetch_req;
    logic [ADDR_WIDTH-1:0] fetch_addr;
    seq_state_t            fsm_state;
    logic                  rd_valid_q;
    logic [ADDR_WIDTH-1:0] rd_idx_q;

    slice_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .clk             (clk),
        .areset          (areset),
        .enable          (enable),
        .step_counter    (step_counter),
        .seq_length      (seq_length),
        .num_repetitions (num_repetitions),
        .fetch_req       (fetch_req),
        .fetch_addr      (fetch_addr),
        .rep_count       (rep_count),
        .state           (fsm_state),
        .error           (error)
    );

    assign bram_en   = fetch_req;
    assign bram_addr = fetch_addr;
    assign state     = fsm_state;
    assign done      = (fsm_state == SEQ_DONE);

    // rd_valid_q marks the cycle bram_rdata carries the word for rd_idx_q.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            rd_valid_q  <= 1'b0;
            rd_idx_q    <= '0;
            slice_valid <= 1'b0;
            slice_data  <= '0;
            slice_index <= '0;
        end else if (!enable) begin
            rd_valid_q  <= 1'b0;
            slice_valid <= 1'b0;
        end else begin
            rd_valid_q  <= fetch_req;
            rd_idx_q    <= fetch_addr;
            slice_valid <= rd_valid_q;
            if (rd_valid_q) begin
                slice_data  <= bram_rdata;
                slice_index <= rd_idx_q;
            end
        end
    end

endmodule

// File: tb/tb_sequence_slice_player.sv
// Directed bench for sequence_slice_player with a behavioural BRAM.
module tb_sequence_slice_player;
    import seq_pkg::*;

    localparam int AW = 14;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          areset;
    logic          enable;
    logic [31:0]   step_counter;
    logic [AW:0]   seq_length;
    logic [31:0]   num_repetitions;
    logic          bram_en;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_rdata = '0;
    logic [DW-1:0] slice_data;
    logic          slice_valid;
    logic [AW-1:0] slice_index;
    logic [31:0]   rep_count;
    logic [1:0]    state;
    logic          done;
    logic          error;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    int            en_cyc[$];
    int            sv_cyc[$];
    logic [AW-1:0] sv_idx[$];
    logic [DW-1:0] sv_dat[$];

    sequence_slice_player #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk             (clk),
        .areset          (areset),
        .enable          (enable),
        .step_counter    (step_counter),
        .seq_length      (seq_length),
        .num_repetitions (num_repetitions),
        .bram_en         (bram_en),
        .bram_addr       (bram_addr),
        .bram_rdata      (bram_rdata),
        .slice_data      (slice_data),
        .slice_valid     (slice_valid),
        .slice_index     (slice_index),
        .rep_count       (rep_count),
        .state           (state),
        .done            (done),
        .error           (error)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] bram_word(input logic [AW-1:0] a);
        slice_t s;
        s.ch0 = {2'b01, a};
        s.ch1 = {2'b10, a};
        s.ch2 = ~{2'b00, a};
        s.ch3 = {2'b11, a} ^ 16'h0A5A;
        return s;
    endfunction

    always @(posedge clk) begin
        if (bram_en)
            bram_rdata <= bram_word(bram_addr);
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Records what the DUT shows after each edge, tagged with that edge's number.
    always @(posedge clk) begin
        #2;
        if (bram_en)
            en_cyc.push_back(cyc);
        if (slice_valid) begin
            sv_cyc.push_back(cyc);
            sv_idx.push_back(slice_index);
            sv_dat.push_back(slice_data);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mon;
        en_cyc.delete();
        sv_cyc.delete();
        sv_idx.delete();
        sv_dat.delete();
    endtask

    task automatic start_run(input int len, input int reps, input logic [31:0] step,
                             output int s_edge);
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        clear_mon();
        seq_length      = len[AW:0];
        num_repetitions = reps;
        step_counter    = step;
        enable          = 1'b1;
        s_edge          = cyc + 1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s;
        int ex[9];
        int last;

        areset = 1'b1;
        enable = 1'b0;
        step_counter = '0;
        seq_length = '0;
        num_repetitions = '0;
        wait_cyc(3);
        check("rst_state", state, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_rep", rep_count, 0);
        check("rst_bram_en", bram_en, 0);
        check("rst_valid", slice_valid, 0);
        check("rst_data", slice_data, 0);
        areset = 1'b0;
        wait_cyc(2);

        // Length 4, two passes, one step every 10 cycles.
        start_run(4, 2, 32'd100, s);
        ex[0] = s;
        for (int k = 1; k <= 8; k++) begin
            wait_cyc(10);
            step_counter = step_counter + 32'd1;
            ex[k] = cyc + 1;
        end
        wait_cyc(6);
        check("t1_en_count", en_cyc.size(), 8);
        check("t1_sv_count", sv_cyc.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < en_cyc.size())
                check($sformatf("t1_en_cyc%0d", i), en_cyc[i], ex[i]);
            if (i < sv_cyc.size()) begin
                check($sformatf("t1_sv_cyc%0d", i), sv_cyc[i], ex[i] + 2);
                check($sformatf("t1_idx%0d", i), sv_idx[i], i % 4);
                check($sformatf("t1_dat%0d", i), sv_dat[i], bram_word(AW'(i % 4)));
            end
        end
        check("t1_done", done, 1);
        check("t1_state", state, 2);
        check("t1_rep", rep_count, 2);
        check("t1_error", error, 0);
        check("t1_hold_idx", slice_index, 3);
        step_counter = step_counter + 32'd1;
        wait_cyc(5);
        check("t1_done_ignores_step", en_cyc.size(), 8);

        // One step per cycle, length 3, endless.
        start_run(3, 0, 32'd500, s);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            step_counter = step_counter + 32'd1;
        end
        wait_cyc(5);
        check("t2_sv_count", sv_cyc.size(), 13);
        for (int i = 0; i < 13; i++) begin
            if (i < sv_cyc.size()) begin
                check($sformatf("t2_sv_cyc%0d", i), sv_cyc[i], s + 2 + i);
                check($sformatf("t2_idx%0d", i), sv_idx[i], i % 3);
            end
        end
        check("t2_rep", rep_count, 4);
        check("t2_error", error, 0);
        check("t2_state", state, 1);

        // Step counter wrap is a normal +1, then a +5 jump.
        start_run(8, 0, 32'hFFFF_FFFE, s);
        wait_cyc(5);
        step_counter = 32'hFFFF_FFFF;
        wait_cyc(5);
        step_counter = 32'h0000_0000;
        wait_cyc(5);
        check("t3_sv_count", sv_cyc.size(), 3);
        for (int i = 0; i < 3; i++)
            if (i < sv_idx.size())
                check($sformatf("t3_idx%0d", i), sv_idx[i], i);
        check("t3_error", error, 0);
        step_counter = 32'd5;
        wait_cyc(5);
        check("t4_sv_count", sv_cyc.size(), 4);
        check("t4_idx", slice_index, 3);
        check("t4_error", error, 1);
        step_counter = 32'd6;
        wait_cyc(5);
        check("t4_idx_next", slice_index, 4);
        check("t4_error_sticky", error, 1);
        start_run(4, 0, 32'd0, s);
        @(negedge clk);
        check("t4_error_cleared", error, 0);

        // Zero length at start.
        start_run(0, 1, 32'd50, s);
        wait_cyc(2);
        step_counter = 32'd51;
        wait_cyc(5);
        check("t5_en_count", en_cyc.size(), 0);
        check("t5_sv_count", sv_cyc.size(), 0);
        check("t5_state", state, 2);
        check("t5_done", done, 1);
        check("t5_error", error, 1);

        // Enable dropped one cycle after a step.
        start_run(4, 0, 32'd10, s);
        wait_cyc(5);
        step_counter = 32'd11;
        wait_cyc(5);
        clear_mon();
        step_counter = 32'd12;
        @(negedge clk);
        enable = 1'b0;
        wait_cyc(5);
        check("t6_en_count", en_cyc.size(), 1);
        check("t6_sv_count", sv_cyc.size(), 0);
        check("t6_state", state, 0);
        check("t6_hold_idx", slice_index, 1);
        check("t6_hold_data", slice_data, bram_word(AW'(1)));

        // Asynchronous reset in the middle of a run.
        start_run(2, 0, 32'd20, s);
        for (int k = 0; k < 3; k++) begin
            wait_cyc(4);
            step_counter = step_counter + 32'd1;
        end
        wait_cyc(4);
        check("t7_pre_rep", rep_count, 1);
        last = sv_idx.size();
        check("t7_pre_sv_count", last, 4);
        @(negedge clk);
        areset = 1'b1;
        #1;
        check("t7_state", state, 0);
        check("t7_rep", rep_count, 0);
        check("t7_idx", slice_index, 0);
        check("t7_data", slice_data, 0);
        check("t7_valid", slice_valid, 0);
        check("t7_bram_en", bram_en, 0);
        wait_cyc(2);
        areset = 1'b0;
        wait_cyc(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sequence_slice_player.md
Name: sequence_slice_player

Overview:
- Sits directly downstream of the sequence step counter.
- Turns each increment of the 32-bit step count into a read of the next slot of a sequence-slice BRAM. Slot address = step mod seq_length, kept as an incremental wrap counter (no divider).
- Presents the fetched slice word with a valid pulse to the DAC offset/amplitude stage.
- Counts completed passes and stops after a programmed number of repetitions.

Parameters:
- ADDR_WIDTH, 14, BRAM slot address width; depth = 2^ADDR_WIDTH.
- DATA_WIDTH, 64, slice word width (4 channels x 16 bit).

Ports:
- clk  in  1  system clock.
- areset  in  1  asynchronous reset, active-high.
- enable  in  1  level; high = play, low = stop and flush.
- step_counter  in  32  step count from the sequence step counter.
- seq_length  in  ADDR_WIDTH+1  slots per pass; latched at start.
- num_repetitions  in  32  passes to play; 0 = endless; latched at start.
- bram_en  out  1  read strobe.
- bram_addr  out  ADDR_WIDTH  read address.
- bram_rdata  in  DATA_WIDTH  read data, valid 1 cycle after bram_en.
- slice_data  out  DATA_WIDTH  current slice word.
- slice_valid  out  1  one-cycle pulse when slice_data updates.
- slice_index  out  ADDR_WIDTH  slot index of slice_data.
- rep_count  out  32  completed passes.
- state  out  2  IDLE=0, RUN=1, DONE=2.
- done  out  1  high while in DONE.
- error  out  1  sticky: step skip or seq_length==0; cleared only at start.

Behaviour:
- Reset (async, areset=1): state=IDLE and all outputs 0; internal prev_step, addr, length and reps = 0; pipeline valid bits = 0.

State machine:
- IDLE + enable=1 (start):
  - latch seq_length and num_repetitions; prev_step<=step_counter; addr<=0; rep_count<=0; error<=0.
  - If latched length==0: go to DONE with error=1, no fetch.
  - Otherwise go to RUN and issue a prime fetch of slot 0 in the same cycle.
- RUN, step detect: delta = step_counter - prev_step (mod 2^32). On delta!=0, prev_step<=step_counter and advance once.
  - delta!=1 sets error but still advances exactly one slot.
  - 0xFFFFFFFF->0 is a normal +1 step.
- Advance, non-wrap (addr != length-1): addr+1, fetch.
- Advance, wrap (addr == length-1): addr<=0, rep_count+1.
  - If num_repetitions!=0 and rep_count+1==num_repetitions: go to DONE, no fetch.
  - Otherwise fetch slot 0.
- DONE: ignore steps; slice_data and slice_index hold the last value.
- enable=0 in any state: IDLE next cycle.
  - Flush in-flight fetches (no further slice_valid).
  - slice_data, slice_index and rep_count hold until the next start.

Fetch pipeline and timing:
- Fully pipelined; one advance per cycle is sustainable (stepSize=1).
- Cycle N: step_counter change sampled at edge N.
- N+1: bram_en=1, bram_addr=new addr.
- N+2: bram_rdata valid.
- N+3: slice_data and slice_index registered, slice_valid=1.
- Fixed latency of 3 cycles from step change to slice_valid; prime fetch has the same latency from start.
- bram_en is high only on fetch cycles.
- A step change in the same cycle as a DONE transition is ignored.
- areset mid-operation aborts immediately; the pipeline is discarded.

Arithmetic:
- addr compare uses ADDR_WIDTH+1 bits against length-1.
- rep_count wraps mod 2^32 in endless mode.

Decomposition:
- Shared package seq_pkg:
  - state encoding (SEQ_IDLE/RUN/DONE);
  - default ADDR_WIDTH and DATA_WIDTH;
  - slice_t typedef (DATA_WIDTH) with per-channel field widths.
- Natural sub-module slice_addr_gen:
  - owns step detect, wrap counter, repetition counter and FSM;
  - emits fetch_req and fetch_addr.
- The top level adds the 2-stage read/present pipeline with flush.

Test Plan:
- Length 4, reps 2, step_counter +1 every 10 cycles from 100:
  - slice_index sequence 0,1,2,3,0,1,2,3 (prime slot 0 plus 7 advances); a further step then sets done=1 and rep_count=2;
  - no further bram_en after the step that completes pass 2.
- Step latency: step change at cycle N -> bram_en at N+1 and slice_valid at N+3 with slice_data = BRAM content of the new slot.
- stepSize=1 (step_counter +1 every cycle), length 3, reps 0:
  - slice_valid high every cycle after fill;
  - indices 0,1,2,0,1,2...; rep_count increments every 3 cycles; error=0.
- step_counter from 0xFFFFFFFE to 0xFFFFFFFF to 0x0 -> two normal advances, error=0.
- step_counter jumps +5 -> single advance, error=1 sticky until next start.
- seq_length=0 at start -> DONE, error=1, bram_en never asserted.
- enable dropped 1 cycle after a step -> no slice_valid from the flushed fetch; state=IDLE.
- areset pulsed mid-RUN -> all outputs 0 immediately.
